time_base: RTL

Generates the shared timing strobes consumed by every tracking channel: accum_sample_enable, pre_tic_enable, tic_enable, and the accumulation-interrupt timing.
- Sits directly upstream of the channel array, one instance per correlator.
- Tic and accumulation-interrupt periods are programmable from the bus.
- A level interrupt with an overrun flag gives the processor its read handshake.

---
 rtl/time_base.sv | 109 ++++++++++
 1 files changed

// File: rtl/time_base.sv
// Shared timing strobes for the tracking channel array: synchronised sample
// enable, programmable tic epoch and accumulation-interrupt epoch with handshake.
module time_base #(
    parameter logic [23:0] TIC_DIV_RST   = 24'd49999,
    parameter logic [23:0] ACCUM_DIV_RST = 24'd8749
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sample_clk,
    input  logic [23:0] tic_divide_in,
    input  logic        tic_divide_wr,
    input  logic [23:0] accum_divide_in,
    input  logic        accum_divide_wr,
    input  logic        int_clear,
    output logic        accum_sample_enable,
    output logic        pre_tic_enable,
    output logic        tic_enable,
    output logic        accum_enable,
    output logic        accum_int,
    output logic        overrun,
    output logic [23:0] tic_count,
    output logic [23:0] accum_count
);

    logic [23:0] tic_divide;
    logic [23:0] accum_divide;
    logic        sample_sync1;
    logic        sample_sync2;
    logic        sample_hist;
    logic        accum_terminal;

    assign pre_tic_enable = (tic_count == 24'd0);
    assign accum_terminal = (accum_count == 24'd0);

    // sample_clk is asynchronous: two flops for metastability, a third for edge history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sample_sync1        <= 1'b0;
            sample_sync2        <= 1'b0;
            sample_hist         <= 1'b0;
            accum_sample_enable <= 1'b0;
        end else begin
            sample_sync1        <= sample_clk;
            sample_sync2        <= sample_sync1;
            sample_hist         <= sample_sync2;
            accum_sample_enable <= sample_sync2 & ~sample_hist;
        end
    end

    // Divide registers only feed the reload, so a write never disturbs the running count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tic_divide   <= TIC_DIV_RST;
            accum_divide <= ACCUM_DIV_RST;
        end else begin
            if (tic_divide_wr) begin
                tic_divide <= tic_divide_in;
            end
            if (accum_divide_wr) begin
                accum_divide <= accum_divide_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tic_count  <= TIC_DIV_RST;
            tic_enable <= 1'b0;
        end else begin
            tic_enable <= pre_tic_enable;
            if (pre_tic_enable) begin
                tic_count <= tic_divide;
            end else begin
                tic_count <= tic_count - 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            accum_count  <= ACCUM_DIV_RST;
            accum_enable <= 1'b0;
        end else begin
            accum_enable <= accum_terminal;
            if (accum_terminal) begin
                accum_count <= accum_divide;
            end else begin
                accum_count <= accum_count - 24'd1;
            end
        end
    end

    // A clear coinciding with a new epoch drops the stale overrun but keeps the new interrupt
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            accum_int <= 1'b0;
            overrun   <= 1'b0;
        end else if (int_clear) begin
            accum_int <= accum_enable;
            overrun   <= 1'b0;
        end else if (accum_enable) begin
            accum_int <= 1'b1;
            if (accum_int) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
